// File: rtl/wordle_pkg.sv
// Shared constants, colour codes and scorer state type for the Wordle row datapath.
package wordle_pkg;

    localparam int unsigned LETTER_W = 5;
    localparam int unsigned CELL_W   = 7;
    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned ROW_W    = 35;
    localparam int unsigned WORD_W   = 25;
    localparam int unsigned COLOR_W  = 2;

    localparam logic [COLOR_W-1:0] COLOR_NONE   = 2'b00;
    localparam logic [COLOR_W-1:0] COLOR_GRAY   = 2'b01;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW = 2'b10;
    localparam logic [COLOR_W-1:0] COLOR_GREEN  = 2'b11;

    localparam logic [LETTER_W-1:0] LETTER_COUNT = 5'd26;
    localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_DONE
    } scorer_state_e;

    typedef logic [NUM_COLS-1:0][LETTER_W-1:0] word_t;
    typedef logic [NUM_COLS-1:0][COLOR_W-1:0]  colors_t;

    // Codes 26..31 are blanks: they are carried through but never match anything.
    function automatic logic is_letter(input logic [LETTER_W-1:0] code);
        return code < LETTER_COUNT;
    endfunction

endpackage

// File: rtl/guess_scorer.sv
// Multi-cycle Wordle row scorer: one green pass, then one yellow search per column.
// Define WORDLE_DUP_AWARE_EN for duplicate-aware yellows; otherwise naive yellow scoring.
module guess_scorer
    import wordle_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  row_in,
    input  logic [WORD_W-1:0] target,
    output logic              busy,
    output logic              out_valid,
    output logic [ROW_W-1:0]  row_out,
    output logic              win
);

    scorer_state_e         state_q, state_d;
    word_t                 letter_q, letter_d;
    word_t                 target_q, target_d;
    colors_t               color_q, color_d;
    logic [NUM_COLS-1:0]   used_q, used_d;
    logic [2:0]            col_q, col_d;
    logic [ROW_W-1:0]      row_out_q, row_out_d;
    logic                  win_q, win_d;

    logic [LETTER_W-1:0]   cur_letter;
    logic                  hit;
    logic                  all_green;
`ifdef WORDLE_DUP_AWARE_EN
    logic [2:0]            hit_idx;
`endif

    // Incoming colour bits are discarded on capture.
    logic unused_row_in_colors;
    always_comb begin
        unused_row_in_colors = 1'b0;
        for (int unsigned k = 0; k < NUM_COLS; k++) begin
            unused_row_in_colors = unused_row_in_colors ^ (^row_in[CELL_W*k+LETTER_W +: COLOR_W]);
        end
    end

    // Priority search of the target for the letter at the current column.
    always_comb begin
        cur_letter = letter_q[col_q];
        hit        = 1'b0;
`ifdef WORDLE_DUP_AWARE_EN
        hit_idx    = '0;
`endif
        for (int unsigned j = 0; j < NUM_COLS; j++) begin
`ifdef WORDLE_DUP_AWARE_EN
            if (!hit && !used_q[j] && is_letter(cur_letter) && target_q[j] == cur_letter) begin
                hit     = 1'b1;
                hit_idx = 3'(j);
            end
`else
            if (color_q[j] != COLOR_GREEN && is_letter(cur_letter) && target_q[j] == cur_letter) begin
                hit = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        letter_d  = letter_q;
        target_d  = target_q;
        color_d   = color_q;
        used_d    = used_q;
        col_d     = col_q;
        row_out_d = row_out_q;
        win_d     = win_q;
        all_green = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int unsigned k = 0; k < NUM_COLS; k++) begin
                        letter_d[k] = row_in[CELL_W*k +: LETTER_W];
                        target_d[k] = target[LETTER_W*k +: LETTER_W];
                        color_d[k]  = COLOR_NONE;
                    end
                    used_d  = '0;
                    col_d   = '0;
                    state_d = ST_GREEN;
                end
            end
            ST_GREEN: begin
                for (int unsigned k = 0; k < NUM_COLS; k++) begin
                    if (is_letter(letter_q[k]) && letter_q[k] == target_q[k]) begin
                        color_d[k] = COLOR_GREEN;
                        used_d[k]  = 1'b1;
                    end else begin
                        color_d[k] = COLOR_GRAY;
                    end
                end
                col_d   = '0;
                state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (color_q[col_q] != COLOR_GREEN && hit) begin
                    color_d[col_q] = COLOR_YELLOW;
`ifdef WORDLE_DUP_AWARE_EN
                    used_d[hit_idx] = 1'b1;
`endif
                end
                if (col_q == 3'(NUM_COLS - 1)) begin
                    // Publish using color_d so the last column's result is included.
                    for (int unsigned k = 0; k < NUM_COLS; k++) begin
                        row_out_d[CELL_W*k +: CELL_W] = {color_d[k], letter_q[k]};
                        if (color_d[k] != COLOR_GREEN) all_green = 1'b0;
                    end
                    win_d   = all_green;
                    state_d = ST_DONE;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            letter_q  <= {NUM_COLS{LETTER_BLANK}};
            target_q  <= {NUM_COLS{LETTER_BLANK}};
            color_q   <= '0;
            used_q    <= '0;
            col_q     <= '0;
            row_out_q <= '0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            letter_q  <= letter_d;
            target_q  <= target_d;
            color_q   <= color_d;
            used_q    <= used_d;
            col_q     <= col_d;
            row_out_q <= row_out_d;
            win_q     <= win_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign row_out   = row_out_q;
    assign win       = win_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed + randomized bench for guess_scorer against a letter-count reference model.
module tb_guess_scorer;
    import wordle_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [34:0] row_in;
    logic [24:0] target;
    logic        busy;
    logic        out_valid;
    logic [34:0] row_out;
    logic        win;

    int checks   = 0;
    int failures = 0;

    guess_scorer dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .row_in    (row_in),
        .target    (target),
        .busy      (busy),
        .out_valid (out_valid),
        .row_out   (row_out),
        .win       (win)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Guess row with random (ignored) colour bits.
    function automatic logic [34:0] mk_row(input int l0, input int l1, input int l2, input int l3, input int l4);
        int l[5];
        logic [34:0] r;
        l = '{l0, l1, l2, l3, l4};
        for (int i = 0; i < 5; i++) r[7*i +: 7] = {2'($urandom_range(3)), 5'(l[i])};
        return r;
    endfunction

    function automatic logic [24:0] mk_word(input int l0, input int l1, input int l2, input int l3, input int l4);
        int l[5];
        logic [24:0] r;
        l = '{l0, l1, l2, l3, l4};
        for (int i = 0; i < 5; i++) r[5*i +: 5] = 5'(l[i]);
        return r;
    endfunction

    function automatic logic [34:0] mk_scored(input int l[5], input int c[5]);
        logic [34:0] r;
        for (int i = 0; i < 5; i++) r[7*i +: 7] = {2'(c[i]), 5'(l[i])};
        return r;
    endfunction

    // Reference: {win, row}. Yellows draw from per-letter counts of unmatched target letters.
    function automatic logic [35:0] model(input logic [34:0] g, input logic [24:0] t);
        int gl[5];
        int tl[5];
        int col[5];
        int cnt[32];
        bit w;
        logic [35:0] r;
        foreach (cnt[c]) cnt[c] = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i] = int'(g[7*i +: 5]);
            tl[i] = int'(t[5*i +: 5]);
        end
        for (int i = 0; i < 5; i++) col[i] = (gl[i] < 26 && gl[i] == tl[i]) ? 3 : 1;
`ifdef WORDLE_DUP_AWARE_EN
        for (int i = 0; i < 5; i++) if (col[i] != 3 && tl[i] < 26) cnt[tl[i]]++;
        for (int i = 0; i < 5; i++) begin
            if (col[i] != 3 && gl[i] < 26 && cnt[gl[i]] > 0) begin
                col[i] = 2;
                cnt[gl[i]]--;
            end
        end
`else
        for (int i = 0; i < 5; i++) begin
            if (col[i] != 3 && gl[i] < 26) begin
                for (int j = 0; j < 5; j++) if (col[j] != 3 && tl[j] == gl[i]) col[i] = 2;
            end
        end
`endif
        w = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r[7*i +: 7] = {2'(col[i]), 5'(gl[i])};
            if (col[i] != 3) w = 1'b0;
        end
        r[35] = w;
        return r;
    endfunction

    // Called at a negedge; start is sampled at the next posedge (edge n).
    task automatic do_op(input logic [34:0] g, input logic [24:0] t, input bit poke, input string tag);
        logic [35:0] exp;
        exp    = model(g, t);
        row_in = g;
        target = t;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        row_in = 35'({$urandom, $urandom});
        target = 25'($urandom);
        chk({tag, ":busy_n"}, 64'(busy), 64'(1));
        chk({tag, ":valid_n"}, 64'(out_valid), 64'(0));
        for (int k = 1; k <= 7; k++) begin
            if (poke && (k == 2 || k == 7)) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("%s:valid_%0d", tag, k), 64'(out_valid), 64'(k == 6));
            chk($sformatf("%s:busy_%0d", tag, k), 64'(busy), 64'(k < 7));
            if (k >= 6) begin
                chk($sformatf("%s:row_%0d", tag, k), 64'(row_out), 64'(exp[34:0]));
                chk($sformatf("%s:win_%0d", tag, k), 64'(win), 64'(exp[35]));
            end
        end
    endtask

    initial begin
        int apple_l[5];
        int exp_c[5];
        int paper_l[5];
        int puppy_l[5];
        int blank_l[5];
        logic [24:0] apple;
        logic [34:0] g;
        logic [24:0] t;
        int lr[5];
        int lt[5];

        clr_n  = 1'b1;
        start  = 1'b0;
        row_in = '0;
        target = '0;
        #1 clr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:valid", 64'(out_valid), 64'(0));
        chk("rst:row", 64'(row_out), 64'(0));
        chk("rst:win", 64'(win), 64'(0));
        clr_n = 1'b1;
        @(negedge clk);

        apple   = mk_word(0, 15, 15, 11, 4);
        apple_l = '{0, 15, 15, 11, 4};
        paper_l = '{15, 0, 15, 4, 17};
        puppy_l = '{15, 20, 15, 15, 24};
        blank_l = '{0, 31, 15, 11, 4};

        do_op(mk_row(0, 15, 15, 11, 4), apple, 1'b0, "apple");
        exp_c = '{3, 3, 3, 3, 3};
        chk("apple:const_row", 64'(row_out), 64'(mk_scored(apple_l, exp_c)));
        chk("apple:const_win", 64'(win), 64'(1));

        do_op(mk_row(15, 0, 15, 4, 17), apple, 1'b0, "paper");
        exp_c = '{2, 2, 3, 2, 1};
        chk("paper:const_row", 64'(row_out), 64'(mk_scored(paper_l, exp_c)));
        chk("paper:const_win", 64'(win), 64'(0));

        do_op(mk_row(15, 20, 15, 15, 24), apple, 1'b0, "puppy");
`ifdef WORDLE_DUP_AWARE_EN
        exp_c = '{2, 1, 3, 1, 1};
`else
        exp_c = '{2, 1, 3, 2, 1};
`endif
        chk("puppy:const_row", 64'(row_out), 64'(mk_scored(puppy_l, exp_c)));

        do_op(mk_row(0, 31, 15, 11, 4), apple, 1'b0, "blank");
        exp_c = '{3, 1, 3, 3, 3};
        chk("blank:const_row", 64'(row_out), 64'(mk_scored(blank_l, exp_c)));
        chk("blank:cell1", 64'(row_out[13:7]), 64'({2'b01, 5'd31}));

        // Extra starts at cycles 2 and 7 are dropped; the op that follows starts at n+8.
        do_op(mk_row(15, 0, 15, 4, 17), apple, 1'b1, "poke");
        do_op(mk_row(4, 11, 0, 15, 15), apple, 1'b0, "b2b");

        // Abort mid-operation.
        row_in = mk_row(0, 15, 15, 11, 4);
        target = apple;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("abort:busy", 64'(busy), 64'(0));
        chk("abort:valid", 64'(out_valid), 64'(0));
        chk("abort:row", 64'(row_out), 64'(0));
        chk("abort:win", 64'(win), 64'(0));
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("abort:no_valid_%0d", k), 64'(out_valid), 64'(0));
        end
        do_op(mk_row(15, 0, 15, 4, 17), apple, 1'b0, "post_abort");

        // Random rows over a small alphabet to force duplicates, with occasional blanks.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 5; i++) begin
                lr[i] = ($urandom_range(7) == 0) ? int'($urandom_range(31, 26)) : int'($urandom_range(4));
                lt[i] = ($urandom_range(9) == 0) ? int'($urandom_range(31, 26)) : int'($urandom_range(4));
            end
            g = mk_row(lr[0], lr[1], lr[2], lr[3], lr[4]);
            t = mk_word(lt[0], lt[1], lt[2], lt[3], lt[4]);
            do_op(g, t, bit'($urandom_range(1)), $sformatf("rnd%0d", n));
            if ($urandom_range(1) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_scorer.md
# guess_scorer

Multi-cycle Wordle row scorer between the letter-selection stage and the display register file. On a start pulse it captures one submitted 35-bit guess row and the 25-bit target word, colours each cell green/yellow/gray with duplicate-letter accounting, and returns the coloured row plus a win flag. The top-level game FSM writes the result into the display row and advances the row counter.

## Interface
- No parameters; widths are fixed by package constants.
- clk  in  1  system clock (50 MHz)
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- row_in  in  35  guess row; cell k = row_in[7k +: 7] = {color[1:0], letter[4:0]}; incoming color bits ignored
- target  in  25  target word; letter k = target[5k +: 5]
- busy  out  1  high while state != IDLE
- out_valid  out  1  one-cycle pulse; row_out/win valid
- row_out  out  35  scored row, same cell format, color bits overwritten
- win  out  1  all five cells green

## Operation
- Letter code: A=0 … Z=25. Codes 26–31 are blank and never match; they score gray.
- Colors: 2'b00 unscored, 2'b01 gray, 2'b10 yellow, 2'b11 green.
- FSM states: IDLE, GREEN, YELLOW, DONE.
- IDLE:
  - start=1 captures row_in letters and target into internal registers.
  - Clears the 5-bit target-used mask and moves to GREEN.
- GREEN (1 cycle):
  - All five positions compared in parallel.
  - Match → cell green and used[k]=1; otherwise cell provisionally gray.
  - Then YELLOW with col=0.
- YELLOW (5 cycles, col 0..4, one per cycle):
  - A non-green cell at col is searched against target positions j with used[j]=0 and target[j]==letter.
  - The lowest such j is marked used and the cell becomes yellow; if none, it stays gray.
  - col=4 → DONE.
- DONE (1 cycle): out_valid=1, then IDLE.
- row_out, win: registered; updated on entry to DONE; held until the next DONE or reset.
- Captured operands are used throughout the operation; row_in and target changes after capture are ignored.
- start while busy: ignored, not queued.
- Blank letters are still captured and returned unchanged.

## Timing
- start high at IDLE edge n: GREEN after n, YELLOW after n+1 (col k processed at edge n+2+k), DONE after n+6, IDLE after n+7.
- out_valid is high for exactly the cycle between edges n+6 and n+7.
- Latency start→out_valid: 6 cycles.
- busy is high over the same interval as the operation, n through n+7.
- A start at the DONE→IDLE edge is ignored; the earliest accepted restart is edge n+8.
- Back-to-back throughput: one row per 8 cycles.
- Reset values: busy=0, out_valid=0, row_out=35'd0, win=0, state IDLE, used=0, col=0.
- clr_n low at any time, including mid-operation, aborts immediately with no out_valid and no partial result.

## Configuration
- WORDLE_DUP_AWARE_EN defined:
  - Duplicate-aware scoring as above; the used mask limits yellows to unmatched target occurrences.
- Undefined (naive mode):
  - YELLOW ignores the used mask.
  - A non-green cell is yellow if its letter equals any target letter at a position that is not green.
  - FSM, latency and handshake are identical in both modes.

## Structure
- Shared package wordle_pkg:
  - LETTER_W=5, CELL_W=7, NUM_COLS=5, ROW_W=35, WORD_W=25.
  - COLOR_NONE/GRAY/YELLOW/GREEN.
  - LETTER_BLANK=5'd31.
  - Scorer state enum.
- Single module. The per-column search is a small priority loop, so no sub-module is needed.

## Test plan
- Target APPLE (0,15,15,11,4), guess APPLE, start at cycle 0:
  - out_valid at cycle 6 only; all colors 2'b11; win=1.
- Target APPLE, guess PAPER (15,0,15,4,17):
  - Colors = yellow, yellow, green, yellow, gray; win=0.
- Target APPLE, guess PUPPY (15,20,15,15,24):
  - Duplicate-aware: yellow, gray, green, gray, gray.
  - Without WORDLE_DUP_AWARE_EN: cell3 is yellow.
- start pulsed again at cycles 2 and 7 during an operation:
  - Single out_valid at cycle 6; a start at cycle 8 is accepted, giving out_valid at 14.
- clr_n low at cycle 3 of an operation:
  - busy, out_valid, win and row_out are 0 immediately.
  - No out_valid appears afterward.
  - The next start scores normally.
- Guess containing blank code 31 at col 1 with target APPLE: cell1 is gray and its letter is returned as 31.
